// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per
// cycle on operand magnitudes, then one sign-fixup cycle before DONE.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              dz_q, dz_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rd_lat_q, rd_lat_d;

  // Operand conditioning at accept time
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;

  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && rs1_data[XLEN-1];
    b_neg    = b_signed && rs2_data[XLEN-1];
    a_mag    = a_neg ? (~rs1_data + 1'b1) : rs1_data;
    b_mag    = b_neg ? (~rs2_data + 1'b1) : rs2_data;
  end

  // Per-iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opa_q : {XLEN{1'b0}})};
    div_trial = {acc_q, lo_q[XLEN-1]} - {1'b0, opa_q};
    prod_fix  = neg_q ? (~{acc_q, lo_q} + 1'b1) : {acc_q, lo_q};
    quot_fix  = neg_q ? (~lo_q + 1'b1) : lo_q;
    rem_fix   = rem_neg_q ? (~acc_q + 1'b1) : acc_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opa_d     = opa_q;
    result_d  = result_q;
    rd_d      = rd_q;
    rd_lat_d  = rd_lat_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = CALC;
          cnt_d     = '0;
          op_d      = op;
          rd_lat_d  = rd_in;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          dz_d      = (rs2_data == '0);
          acc_d     = '0;
          // Division keeps the divisor in opa and shifts the dividend out of lo
          if (op[2]) begin
            opa_d = b_mag;
            lo_d  = a_mag;
          end else begin
            opa_d = a_mag;
            lo_d  = b_mag;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      CALC: begin
        if (cnt_q == CW'(XLEN)) begin
          state_d = DONE;
          rd_d    = rd_lat_q;
          case (op_q)
            OP_MUL:                       result_d = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
            OP_DIV:                       result_d = dz_q ? {XLEN{1'b1}} : quot_fix;
            OP_DIVU:                      result_d = lo_q;
            OP_REM:                       result_d = rem_fix;
            default:                      result_d = acc_q;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (op_q[2]) begin
            // Restoring step: keep the subtraction only if it did not go negative
            if (!div_trial[XLEN]) begin
              acc_d = div_trial[XLEN-1:0];
              lo_d  = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              acc_d = {acc_q[XLEN-2:0], lo_q[XLEN-1]};
              lo_d  = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            acc_d = mul_sum[XLEN:1];
            lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      acc_q     <= '0;
      lo_q      <= '0;
      opa_q     <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      rd_lat_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opa_q     <= opa_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      rd_lat_q  <= rd_lat_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, MUL/MULH*, DIV/REM incl. corner cases,
// busy-start rejection, back-to-back accept and mid-operation reset.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request at a negedge; returns 1 time unit after the accept edge.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r);
    @(negedge clk);
    op = o; rs1_data = a; rs2_data = b; rd_in = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen; -1 if it never arrives within the budget.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({busy, done, result, rd_out} !== 39'd0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b done=%b result=%h rd_out=%0d, want all zero",
               busy, done, result, rd_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul_basic;
    int n;
    launch(MUL, 32'd7, 32'd6, 5'd5);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mul_busy: busy=%b want 1", busy);
    end
    wait_done(n);
    n_cmp++;
    if (n !== 33) begin
      n_bad++;
      $display("FAIL mul_latency: %0d edges want 33", n);
    end
    n_cmp++;
    if (result !== 32'd42 || rd_out !== 5'd5 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mul_result: result=%0d rd_out=%0d busy=%b want 42/5/0", result, rd_out, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || result !== 32'd42) begin
      n_bad++;
      $display("FAIL mul_hold: done=%b result=%0d want 0/42", done, result);
    end
    $display("MUL 7*6 -> %0d rd=%0d latency=%0d", result, rd_out, n);
  endtask

  task automatic test_mul_high;
    logic [2:0]  ops [4] = '{MULH, MULHU, MULHSU, MUL};
    logic [31:0] exp [4] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001};
    int n;
    for (int i = 0; i < 4; i++) begin
      launch(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(10 + i));
      wait_done(n);
      n_cmp++;
      if (n !== 33 || result !== exp[i] || rd_out !== 5'(10 + i)) begin
        n_bad++;
        $display("FAIL mul_high[%0d]: op=%0d lat=%0d result=%h rd=%0d want 33/%h/%0d",
                 i, ops[i], n, result, rd_out, exp[i], 10 + i);
      end
      $display("op=%0d -1*-1 -> %h latency=%0d", ops[i], result, n);
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [4] = '{DIV, REM, DIVU, REMU};
    logic [31:0] a   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int n;
    for (int i = 0; i < 4; i++) begin
      launch(ops[i], a[i], b[i], 5'(20 + i));
      wait_done(n);
      n_cmp++;
      if (n !== 33 || result !== exp[i] || rd_out !== 5'(20 + i)) begin
        n_bad++;
        $display("FAIL div[%0d]: op=%0d lat=%0d result=%h rd=%0d want 33/%h/%0d",
                 i, ops[i], n, result, rd_out, exp[i], 20 + i);
      end
      $display("op=%0d %h,%h -> %h latency=%0d", ops[i], a[i], b[i], result, n);
    end
  endtask

  task automatic test_div_special;
    logic [2:0]  ops [6] = '{DIVU, REMU, DIV, REM, DIV, REM};
    logic [31:0] a   [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
    logic [31:0] b   [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    int n;
    for (int i = 0; i < 6; i++) begin
      launch(ops[i], a[i], b[i], 5'd1);
      wait_done(n);
      n_cmp++;
      if (n !== 33 || result !== exp[i]) begin
        n_bad++;
        $display("FAIL div_special[%0d]: op=%0d lat=%0d result=%h want 33/%h",
                 i, ops[i], n, result, exp[i]);
      end
      $display("op=%0d %h,%h -> %h latency=%0d", ops[i], a[i], b[i], result, n);
    end
  endtask

  task automatic test_busy_ignore;
    int n;
    launch(MUL, 32'd7, 32'd6, 5'd3);
    op = DIV; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd9; start = 1'b1;
    repeat (20) @(posedge clk);
    #1 start = 1'b0;
    wait_done(n);
    n_cmp++;
    if (n !== 13 || result !== 32'd42 || rd_out !== 5'd3) begin
      n_bad++;
      $display("FAIL busy_ignore: lat=%0d result=%0d rd=%0d want 33/42/3", 20 + n, result, rd_out);
    end
    $display("MUL 7*6 with start held in CALC -> %0d rd=%0d latency=%0d", result, rd_out, 20 + n);
  endtask

  task automatic test_back_to_back;
    int n;
    launch(MUL, 32'd4, 32'd5, 5'd1);
    wait_done(n);
    n_cmp++;
    if (n !== 33 || result !== 32'd20) begin
      n_bad++;
      $display("FAIL b2b_first: lat=%0d result=%0d want 33/20", n, result);
    end
    op = MUL; rs1_data = 32'd3; rs2_data = 32'd3; rd_in = 5'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== 32'd20) begin
      n_bad++;
      $display("FAIL b2b_accept: busy=%b done=%b result=%0d want 1/0/20", busy, done, result);
    end
    wait_done(n);
    n_cmp++;
    if (n !== 33 || result !== 32'd9 || rd_out !== 5'd2) begin
      n_bad++;
      $display("FAIL b2b_second: lat=%0d result=%0d rd=%0d want 33/9/2", n, result, rd_out);
    end
    $display("back-to-back MUL 3*3 -> %0d rd=%0d latency=%0d", result, rd_out, n);
  endtask

  task automatic test_reset_mid;
    int n;
    int pulses;
    launch(MUL, 32'd7, 32'd6, 5'd7);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, result, rd_out} !== 39'd0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h rd_out=%0d want all zero",
               busy, done, result, rd_out);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL reset_no_done: %0d done cycles want 0", pulses);
    end
    launch(MUL, 32'd2, 32'd2, 5'd4);
    wait_done(n);
    n_cmp++;
    if (n !== 33 || result !== 32'd4 || rd_out !== 5'd4) begin
      n_bad++;
      $display("FAIL reset_recover: lat=%0d result=%0d rd=%0d want 33/4/4", n, result, rd_out);
    end
    $display("after reset MUL 2*2 -> %0d rd=%0d latency=%0d", result, rd_out, n);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    #12;
    test_reset;
    test_mul_basic;
    test_mul_high;
    test_div;
    test_div_special;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
